// File: rtl/gpu_ram_arbiter_4port.sv
// Four-port GPU RAM scheduler with registered command and read-return routing.
// Optional starvation guard: define GPU_ARB_STARVE_GUARD_EN.
module gpu_ram_arbiter_4port #(
  parameter int READ_CLOCK_CYCLES = 2,
  parameter int STARVE_LIMIT      = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  req,
  input  logic [3:0]  req_wr,
  input  logic [3:0]  req_16bit,
  input  logic [79:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic [3:0]  gnt,
  output logic        ram_wr_ena,
  output logic        ram_rd_req,
  output logic        ram_ena_16bit,
  output logic [19:0] ram_address,
  output logic [15:0] ram_data_out,
  input  logic [15:0] ram_data_in,
  output logic [3:0]  rd_rdy,
  output logic [15:0] rd_data
);

  localparam int D = READ_CLOCK_CYCLES + 1;

  logic [3:0]  starved;
  logic [3:0]  pick;
  logic [1:0]  sel;
  logic        any;
  logic        sel_wr;
  logic        sel_16;
  logic [19:0] sel_addr;
  logic [15:0] sel_wdata;

`ifdef GPU_ARB_STARVE_GUARD_EN
  logic [7:0] wait_cnt [4];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++)
        wait_cnt[i] <= 8'd0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (!req[i] || gnt[i])
          wait_cnt[i] <= 8'd0;
        else if (wait_cnt[i] != 8'(STARVE_LIMIT))
          wait_cnt[i] <= wait_cnt[i] + 8'd1;
      end
    end
  end

  // a withdrawn request can never be starved, even with a full counter
  always_comb begin
    starved = '0;
    for (int i = 0; i < 4; i++)
      starved[i] = req[i] &&
                   (wait_cnt[i] == 8'(STARVE_LIMIT));
  end
`else
  assign starved = '0;
`endif

  assign pick = (|starved) ? starved : req;

  always_comb begin
    sel = 2'd0;
    for (int i = 3; i >= 0; i--)
      if (pick[i])
        sel = 2'(i);
  end

  assign any = (|pick) && !reset;

  always_comb begin
    gnt = '0;
    if (any)
      gnt[sel] = 1'b1;
  end

  assign sel_wr    = req_wr[sel];
  assign sel_16    = req_16bit[sel];
  assign sel_addr  = req_addr[20*sel +: 20];
  assign sel_wdata = req_wdata[16*sel +: 16];

  always_ff @(posedge clk) begin
    if (reset) begin
      ram_wr_ena    <= 1'b0;
      ram_rd_req    <= 1'b0;
      ram_ena_16bit <= 1'b0;
      ram_address   <= '0;
      ram_data_out  <= '0;
    end else begin
      ram_wr_ena <= any && sel_wr;
      ram_rd_req <= any && !sel_wr;
      if (any) begin
        ram_ena_16bit <= sel_16;
        ram_address   <= sel_addr;
        ram_data_out  <= sel_16 ? sel_wdata
                                : {8'h00, sel_wdata[7:0]};
      end
    end
  end

  // tag pipeline: one slot per cycle so returns stay in grant order
  logic [D-1:0]      pipe_v;
  logic [D-1:0][1:0] pipe_p;

  always_ff @(posedge clk) begin
    if (reset) begin
      pipe_v <= '0;
      pipe_p <= '0;
    end else begin
      pipe_v <= {pipe_v[D-2:0], any && !sel_wr};
      pipe_p <= {pipe_p[D-2:0], sel};
    end
  end

  always_comb begin
    rd_rdy = '0;
    if (pipe_v[D-1])
      rd_rdy[pipe_p[D-1]] = 1'b1;
  end

  assign rd_data = ram_data_in;

endmodule

// File: tb/tb_gpu_ram_arbiter_4port.sv
// Directed bench for gpu_ram_arbiter_4port.
// Follows GPU_ARB_STARVE_GUARD_EN for the starvation expectations.
module tb_gpu_ram_arbiter_4port;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req, req_wr, req_16bit;
  logic [79:0] req_addr;
  logic [63:0] req_wdata;
  logic [3:0]  gnt;
  logic        ram_wr_ena, ram_rd_req, ram_ena_16bit;
  logic [19:0] ram_address;
  logic [15:0] ram_data_out, ram_data_in;
  logic [3:0]  rd_rdy;
  logic [15:0] rd_data;

  gpu_ram_arbiter_4port #(
    .READ_CLOCK_CYCLES(2),
    .STARVE_LIMIT(8)
  ) dut (
    .clk(clk), .reset(reset), .req(req),
    .req_wr(req_wr), .req_16bit(req_16bit),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .gnt(gnt), .ram_wr_ena(ram_wr_ena),
    .ram_rd_req(ram_rd_req),
    .ram_ena_16bit(ram_ena_16bit),
    .ram_address(ram_address),
    .ram_data_out(ram_data_out),
    .ram_data_in(ram_data_in),
    .rd_rdy(rd_rdy), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [3:0]  req, wr, b16, e_gnt;
    logic        e_wr, e_rd, e_16;
    logic [19:0] e_addr;
    logic [15:0] e_dout;
  } vec_t;

  vec_t v [7];
  logic [3:0] gs [8];
  logic [3:0] rs [8];
  logic [3:0] acc;
  int first3, n0;

  initial begin
    v[0] = '{4'b0001, 4'b0000, 4'b0001, 4'b0001,
             1'b0, 1'b1, 1'b1, 20'h00010, 16'h0F0F};
    v[1] = '{4'b0010, 4'b0010, 4'b0000, 4'b0010,
             1'b1, 1'b0, 1'b0, 20'h0ABCD, 16'h005A};
    v[2] = '{4'b1100, 4'b1000, 4'b1100, 4'b0100,
             1'b0, 1'b1, 1'b1, 20'h12345, 16'hBEEF};
    v[3] = '{4'b1000, 4'b1000, 4'b1000, 4'b1000,
             1'b1, 1'b0, 1'b1, 20'hFFFFF, 16'h1234};
    v[4] = '{4'b1111, 4'b0000, 4'b0000, 4'b0001,
             1'b0, 1'b1, 1'b0, 20'h00010, 16'h000F};
    v[5] = '{4'b0110, 4'b0110, 4'b0010, 4'b0010,
             1'b1, 1'b0, 1'b1, 20'h0ABCD, 16'hA55A};
    v[6] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000,
             1'b0, 1'b0, 1'b1, 20'h0ABCD, 16'hA55A};

    req_addr  = {20'hFFFFF, 20'h12345,
                 20'h0ABCD, 20'h00010};
    req_wdata = {16'h1234, 16'hBEEF,
                 16'hA55A, 16'h0F0F};
    ram_data_in = 16'hBEEF;
    reset = 1'b1;
    req = 4'b1111;
    req_wr = '0;
    req_16bit = '0;

    repeat (2) cyc();
    @(negedge clk);
    chk("rst gnt", gnt, 4'b0000);
    chk("rst strobes",
        {ram_wr_ena, ram_rd_req, ram_ena_16bit}, 3'b000);
    chk("rst addr", ram_address, 20'h0);
    chk("rst dout", ram_data_out, 16'h0);
    chk("rst rd_rdy", rd_rdy, 4'b0000);
    cyc();
    reset = 1'b0;
    req = '0;
    repeat (4) cyc();

    for (int i = 0; i < 7; i++) begin
      req = v[i].req;
      req_wr = v[i].wr;
      req_16bit = v[i].b16;
      @(negedge clk);
      chk($sformatf("vec%0d gnt", i), gnt, v[i].e_gnt);
      cyc();
      req = '0;
      @(negedge clk);
      chk($sformatf("vec%0d cmd", i),
          {ram_wr_ena, ram_rd_req, ram_ena_16bit,
           ram_address, ram_data_out},
          {v[i].e_wr, v[i].e_rd, v[i].e_16,
           v[i].e_addr, v[i].e_dout});
      repeat (4) cyc();
    end

    // single read on port 2
    req = 4'b0100; req_wr = '0; req_16bit = 4'b0100;
    @(negedge clk);
    chk("rd T gnt", gnt, 4'b0100);
    cyc(); req = '0;
    @(negedge clk);
    chk("rd T+1 cmd", {ram_rd_req, ram_wr_ena,
        ram_address}, {1'b1, 1'b0, 20'h12345});
    chk("rd T+1 rdy", rd_rdy, 4'b0000);
    cyc();
    @(negedge clk);
    chk("rd T+2 rdy", rd_rdy, 4'b0000);
    cyc();
    @(negedge clk);
    chk("rd T+3 rdy", rd_rdy, 4'b0100);
    chk("rd T+3 data", rd_data, 16'hBEEF);
    cyc();
    @(negedge clk);
    chk("rd T+4 rdy", rd_rdy, 4'b0000);
    repeat (2) cyc();

    // 8-bit write on port 1
    req = 4'b0010; req_wr = 4'b0010; req_16bit = '0;
    @(negedge clk);
    chk("wr gnt", gnt, 4'b0010);
    cyc(); req = '0;
    @(negedge clk);
    chk("wr cmd", {ram_wr_ena, ram_rd_req,
        ram_ena_16bit, ram_data_out},
        {1'b1, 1'b0, 1'b0, 16'h005A});
    acc = rd_rdy;
    cyc();
    @(negedge clk);
    chk("wr strobe off", ram_wr_ena, 1'b0);
    for (int k = 0; k < 5; k++) begin
      acc |= rd_rdy;
      cyc();
      @(negedge clk);
    end
    chk("wr no rd_rdy", acc, 4'b0000);
    repeat (2) cyc();

    // four reads granted back to back
    req = 4'b1111; req_wr = '0; req_16bit = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      gs[k] = gnt;
      rs[k] = rd_rdy;
      cyc();
      req = req & ~gs[k];
    end
    chk("b2b gnt", {gs[0], gs[1], gs[2], gs[3], gs[4]},
        {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000});
    chk("b2b rdy", {rs[2], rs[3], rs[4], rs[5],
        rs[6], rs[7]},
        {4'b0000, 4'b0001, 4'b0010, 4'b0100,
         4'b1000, 4'b0000});
    repeat (3) cyc();

    // port 0 hogs, port 3 waits
    req = 4'b1001; req_wr = '0; req_16bit = '0;
    first3 = -1;
    n0 = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (gnt[3] && first3 < 0) first3 = k;
      if (gnt[0]) n0++;
      cyc();
      if (first3 >= 0) req[3] = 1'b0;
    end
    req = '0;
`ifdef GPU_ARB_STARVE_GUARD_EN
    chk("starve p3 cycle", first3, 8);
    chk("starve p0 count", n0, 19);
`else
    chk("fixed p3 never", first3, -1);
    chk("fixed p0 count", n0, 20);
`endif
    repeat (4) cyc();

    // reset while a read is in flight
    req = 4'b0010; req_wr = '0; req_16bit = '0;
    @(negedge clk);
    chk("mr gnt", gnt, 4'b0010);
    cyc();
    req = 4'b0001; req_wr = 4'b0001; reset = 1'b1;
    @(negedge clk);
    chk("mr gnt in reset", gnt, 4'b0000);
    cyc();
    reset = 1'b0;
    @(negedge clk);
    chk("mr outs cleared",
        {ram_wr_ena, ram_rd_req, ram_ena_16bit,
         ram_address, ram_data_out, rd_rdy}, 64'h0);
    chk("mr regrant", gnt, 4'b0001);
    cyc();
    req = '0;
    @(negedge clk);
    chk("mr T+3 rdy", rd_rdy, 4'b0000);
    chk("mr held wr", ram_wr_ena, 1'b1);
    cyc();
    @(negedge clk);
    chk("mr T+4 rdy", rd_rdy, 4'b0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gpu_ram_arbiter_4port.md
# gpu_ram_arbiter_4port

Four-requester scheduler for the single GPU RAM read/write port. It sits between the command-FIFO front ends (Z80, RS232, geometry, spare) and the GPU RAM. Each cycle it grants at most one request and issues it to RAM as a registered command. It routes each read's returned data back to its originator after the fixed RAM read latency, and a configurable starvation guard bounds the wait of any low-priority port.

## Interface
Parameters:
- READ_CLOCK_CYCLES, 2: cycles from RAM command visible on ram_* to valid ram_data_in; legal 1..8.
- STARVE_LIMIT, 8: wait-cycle count at which a requester is marked starved; legal 1..255.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- req  in  4  per-port request; port i holds req[i] and its fields stable until gnt[i].
- req_wr  in  4  1 = write, 0 = read.
- req_16bit  in  4  1 = 16-bit access, 0 = 8-bit.
- req_addr  in  80  port i address at [20*i+19:20*i].
- req_wdata  in  64  port i write data at [16*i+15:16*i].
- gnt  out  4  one-hot, combinational; request accepted this cycle.
- ram_wr_ena  out  1  registered one-cycle write strobe.
- ram_rd_req  out  1  registered one-cycle read strobe.
- ram_ena_16bit  out  1  registered access width.
- ram_address  out  20  registered address.
- ram_data_out  out  16  registered write data; [15:8] = 0 when 8-bit.
- ram_data_in  in  16  RAM read data.
- rd_rdy  out  4  one-hot one-cycle pulse: rd_data valid for that port.
- rd_data  out  16  ram_data_in passed through combinationally; latch on rd_rdy.

## Operation
- Selection, evaluated every cycle with no idle state:
  - If any port is starved, grant the lowest-index starved port.
  - Otherwise grant the lowest-index port with req high.
  - No requests means gnt = 0.
- Wait counter, one 8-bit counter per port:
  - Cycle with req[i]=1 and gnt[i]=0: increment, saturating at STARVE_LIMIT.
  - gnt[i]=1 or req[i]=0: clear to 0.
  - Starved means wait counter == STARVE_LIMIT.
- On grant, the selected port's command is registered onto ram_*.
  - ram_wr_ena = req_wr; ram_rd_req = !req_wr.
  - In a cycle with no grant, the next cycle has ram_wr_ena = ram_rd_req = 0; address and data hold their last values.
- Read return tracking:
  - Tag pipeline depth READ_CLOCK_CYCLES+1, each entry {valid, port[1:0]}.
  - Each read grant shifts in {1, port}; every other cycle shifts in {0, x}.
  - Pipeline output drives rd_rdy; writes produce no rd_rdy.
- Throughput is one command per cycle. Back-to-back grants to the same port are allowed when req stays high with new fields after gnt.
- Multiple reads in flight are legal. Returns arrive strictly in grant order.

## Timing
- Grant at cycle T (gnt[i] high during T).
- ram_* command visible at T+1.
- rd_rdy[i] pulses at T+1+READ_CLOCK_CYCLES (T+3 at default).
- Reset:
  - gnt = 0, ram_wr_ena = ram_rd_req = ram_ena_16bit = 0, ram_address = 0, ram_data_out = 0, rd_rdy = 0.
  - All wait counters and tag entries cleared.
- Reset mid-operation: in-flight reads are discarded and no rd_rdy is produced for them. A request held across reset is re-arbitrated from the first cycle after reset deasserts.
- Simultaneous starvation of several ports: lowest index wins. The others keep saturated counters and win on subsequent cycles in index order.
- req dropped before gnt: the request is withdrawn with no side effect and its counter clears.

## Configuration
- GPU_ARB_STARVE_GUARD_EN defined: wait counters and starved override are active as described.
- Not defined:
  - Counters are not built and no port is ever starved.
  - Selection is pure fixed priority, port 0 highest.
  - All other behaviour and timing are identical.

## Test plan
- Single read, port 2, addr 0x12345, READ_CLOCK_CYCLES=2, RAM model returns 0xBEEF: gnt=0100 at T; ram_rd_req=1 and ram_address=0x12345 at T+1; rd_rdy=0100 with rd_data=0xBEEF at T+3.
- 8-bit write, port 1, wdata 0xA55A: ram_wr_ena=1 for exactly one cycle, ram_data_out=0x005A, ram_ena_16bit=0, no rd_rdy ever.
- Ports 0 and 3 request simultaneously, port 0 continuously, STARVE_LIMIT=8, guard on: port 3 granted on the 9th cycle (counter reached 8); port 0 granted on every other cycle.
- Same as previous with guard undefined: port 3 never granted while port 0 holds req.
- Reads from ports 0,1,2,3 granted on 4 consecutive cycles: rd_rdy = 0001, 0010, 0100, 1000 on 4 consecutive cycles starting T+3.
- Port 1 read granted at T, reset asserted at T+1 for one cycle: no rd_rdy at T+3; all outputs 0 during reset.
